// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, fetches from imem over req/ready and forms the next PC at retire.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [31:0] PC,
    input  logic        Retire,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] SignImm,
    output logic [31:0] RetireCnt,
    output logic        FetchErr
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERROR} state_t;
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d, pc_plus4, next_pc;
    logic [WW-1:0] wait_q, wait_d;
    logic req_q, req_d, valid_q, valid_d, err_q, err_d;
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        next_pc  = Jump  ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                   PCSrc ? pc_plus4 + (SignImm << 2) : pc_plus4;
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (ImemReady) begin
                    instr_d = ImemRdata;
                    wait_d  = '0;
                    state_d = EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            EXEC: begin
                if (Retire) begin
                    pc_d    = next_pc;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = ERROR;
        endcase
        // outputs are registered versions of the next-state decode
        req_d   = state_d == FETCH;
        valid_d = state_d == EXEC;
        err_d   = state_d == ERROR;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    assign ImemReq    = req_q;
    assign ImemAddr   = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign Op         = instr_q[31:26];
    assign Funct      = instr_q[5:0];
    assign PC         = pc_q;
    assign RetireCnt  = cnt_q;
    assign FetchErr   = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus randomized checks of pc_fetch_unit against a transaction-level PC model.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ImemReq, ImemReady, InstrValid, Retire, PCSrc, Jump, FetchErr;
    logic [31:0] ImemAddr, ImemRdata, Instr, PC, SignImm, RetireCnt;
    logic [5:0]  Op, Funct;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_pc, m_cnt, m_instr;
    localparam logic [31:0] EXP_RST_PC = 32'h0000_0040;

    pc_fetch_unit #(.RESET_PC(32'h0000_0042), .MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemReady(ImemReady), .ImemRdata(ImemRdata), .InstrValid(InstrValid),
        .Instr(Instr), .Op(Op), .Funct(Funct), .PC(PC), .Retire(Retire),
        .PCSrc(PCSrc), .Jump(Jump), .SignImm(SignImm), .RetireCnt(RetireCnt),
        .FetchErr(FetchErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input int waits, input logic [31:0] word);
        chk("fetch_req", 32'(ImemReq), 32'd1);
        chk("fetch_addr", ImemAddr, m_pc);
        chk("fetch_nvalid", 32'(InstrValid), 32'd0);
        for (int i = 0; i < waits; i++) begin
            ImemReady = 1'b0;
            ImemRdata = $urandom;
            Retire    = 1'($urandom);
            PCSrc     = 1'($urandom);
            Jump      = 1'($urandom);
            @(negedge clk);
            chk("wait_req", 32'(ImemReq), 32'd1);
            chk("wait_addr", ImemAddr, m_pc);
        end
        ImemReady = 1'b1;
        ImemRdata = word;
        @(negedge clk);
        ImemReady = 1'b0;
        ImemRdata = $urandom;
        Retire    = 1'b0;
        m_instr   = word;
        chk("exec_valid", 32'(InstrValid), 32'd1);
        chk("exec_req", 32'(ImemReq), 32'd0);
        chk("instr", Instr, word);
        chk("op", 32'(Op), 32'(word[31:26]));
        chk("funct", 32'(Funct), 32'(word[5:0]));
        chk("exec_pc", PC, m_pc);
    endtask

    task automatic retire(input int hold, input logic pcsrc, input logic jump, input logic [31:0] imm);
        for (int i = 0; i < hold; i++) begin
            Retire  = 1'b0;
            PCSrc   = 1'($urandom);
            Jump    = 1'($urandom);
            SignImm = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(InstrValid), 32'd1);
            chk("hold_pc", PC, m_pc);
            chk("hold_cnt", RetireCnt, m_cnt);
        end
        Retire  = 1'b1;
        PCSrc   = pcsrc;
        Jump    = jump;
        SignImm = imm;
        @(negedge clk);
        Retire = 1'b0;
        PCSrc  = 1'b0;
        Jump   = 1'b0;
        if (jump)       m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, m_instr[25:0]} * 4);
        else if (pcsrc) m_pc = m_pc + 32'd4 + imm * 4;
        else            m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
        chk("ret_pc", PC, m_pc);
        chk("ret_cnt", RetireCnt, m_cnt);
        chk("ret_req", 32'(ImemReq), 32'd1);
        chk("ret_addr", ImemAddr, m_pc);
        chk("ret_nvalid", 32'(InstrValid), 32'd0);
    endtask

    task automatic branch_to(input logic [31:0] target);
        fetch(0, $urandom);
        retire(0, 1'b1, 1'b0, (target - m_pc - 32'd4) >> 2);
    endtask

    initial begin
        logic [31:0] w;
        reset_n   = 1'b0;
        ImemReady = 1'b0;
        ImemRdata = '0;
        Retire    = 1'b0;
        PCSrc     = 1'b0;
        Jump      = 1'b0;
        SignImm   = '0;
        m_pc      = EXP_RST_PC;
        m_cnt     = '0;
        m_instr   = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", PC, EXP_RST_PC);
        chk("rst_req", 32'(ImemReq), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_err", 32'(FetchErr), 32'd0);
        chk("rst_cnt", RetireCnt, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        reset_n = 1'b1;
        #1 chk("idle_req", 32'(ImemReq), 32'd0);
        @(negedge clk);
        chk("first_addr", ImemAddr, EXP_RST_PC);
        for (int i = 0; i < 3; i++) begin
            fetch(0, $urandom);
            retire(0, 1'b0, 1'b0, $urandom);
        end
        chk("t2_cnt", RetireCnt, 32'd3);
        chk("t2_addr", ImemAddr, 32'h0000_004C);
        for (int i = 0; i < 12; i++) begin
            fetch(int'($urandom_range(0, 3)), $urandom);
            retire(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), $urandom);
        end
        branch_to(32'h0000_0010);
        fetch(1, $urandom);
        retire(1, 1'b1, 1'b0, 32'hFFFF_FFFC);
        chk("t3_addr", ImemAddr, 32'h0000_0004);
        branch_to(32'h1000_0000);
        w = ($urandom & 32'hFC00_0000) | 32'h0000_0040;
        fetch(2, w);
        retire(1, 1'b1, 1'b1, $urandom);
        chk("t4_pc", PC, 32'h1000_0100);
        branch_to(32'hFFFF_FFFC);
        fetch(3, $urandom);
        retire(0, 1'b0, 1'b0, $urandom);
        chk("wrap_pc", PC, 32'h0000_0000);
        fetch(1, $urandom);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(InstrValid), 32'd0);
        chk("t6_pc", PC, EXP_RST_PC);
        chk("t6_cnt", RetireCnt, 32'd0);
        chk("t6_instr", Instr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_pc  = EXP_RST_PC;
        m_cnt = '0;
        @(negedge clk);
        chk("t5_start_req", 32'(ImemReq), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_wait_req", 32'(ImemReq), 32'd1);
            chk("t5_wait_err", 32'(FetchErr), 32'd0);
        end
        @(negedge clk);
        chk("t5_err", 32'(FetchErr), 32'd1);
        chk("t5_req", 32'(ImemReq), 32'd0);
        chk("t5_valid", 32'(InstrValid), 32'd0);
        ImemReady = 1'b1;
        Retire    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ImemRdata = $urandom;
            @(negedge clk);
            chk("t5_late_err", 32'(FetchErr), 32'd1);
            chk("t5_late_valid", 32'(InstrValid), 32'd0);
            chk("t5_late_pc", PC, m_pc);
            chk("t5_late_cnt", RetireCnt, 32'd0);
        end
        ImemReady = 1'b0;
        Retire    = 1'b0;
        reset_n   = 1'b0;
        #1 chk("t5_clr_err", 32'(FetchErr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        fetch(0, $urandom);
        retire(0, 1'b0, 1'b0, $urandom);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
